// File: rtl/dna_seq_matcher.sv
// dna_seq_matcher: streaming pattern matcher that counts hits of a programmable
// symbol pattern and locks once THRESH hits have been counted.
//
// Ports:
//   clk        - single clock, all state changes on its rising edge
//   reset      - asynchronous active-low reset
//   in_valid   - qualifies in
//   in         - incoming symbol
//   cfg_we     - pattern slot write strobe (slot cfg_idx <= cfg_char)
//   cfg_idx    - pattern slot index, 0 = first (oldest) symbol
//   cfg_char   - symbol written to slot cfg_idx
//   cfg_len_we - pattern length write strobe
//   cfg_len    - new pattern length
//   clr        - synchronous clear of count and history
//   cnt        - registered match count
//   match      - registered one-cycle pulse per counted match
//   danger     - combinational flag: locked, or this cycle's hit will lock
//
// Build option: define DNA_MATCH_OVERLAP_EN to count overlapping matches;
// by default history is discarded after each hit so matches never share symbols.
module dna_seq_matcher #(
    parameter int                          CHAR_W  = 8,
    parameter int                          MAX_LEN = 8,
    parameter int                          THRESH  = 3,
    parameter logic [MAX_LEN*CHAR_W-1:0]   DEF_PAT = "ATATGCGA",
    parameter int                          DEF_LEN = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    input  logic [CHAR_W-1:0]              in,
    input  logic                           cfg_we,
    input  logic [$clog2(MAX_LEN)-1:0]     cfg_idx,
    input  logic [CHAR_W-1:0]              cfg_char,
    input  logic                           cfg_len_we,
    input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
    input  logic                           clr,
    output logic [4:0]                     cnt,
    output logic                           match,
    output logic                           danger
);
    localparam int LW = $clog2(MAX_LEN + 1);

    // The compare window always includes the incoming symbol, so only the
    // newest MAX_LEN-1 accepted symbols can ever reach the comparator; the
    // fill counter still tracks up to MAX_LEN accepted symbols.
    logic [CHAR_W-1:0] hist_q [MAX_LEN-1];
    logic [CHAR_W-1:0] hist_d [MAX_LEN-1];
    logic [CHAR_W-1:0] pat_q  [MAX_LEN];
    logic [CHAR_W-1:0] pat_d  [MAX_LEN];
    logic [CHAR_W-1:0] win    [MAX_LEN];
    logic [LW-1:0]     fill_q, fill_d, len_q, len_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              match_q, match_d;
    logic              accept, len_ok, eq, hit;

    // win[a] is the symbol a positions back from the incoming one
    always_comb begin
        win[0] = in;
        for (int a = 1; a < MAX_LEN; a++) win[a] = hist_q[a-1];
    end

    assign len_ok = (len_q != '0) && (int'(len_q) <= MAX_LEN);
    assign accept = in_valid && (int'(cnt_q) < THRESH) && !cfg_we && !cfg_len_we && !clr;

    // Newest symbol lines up with pattern slot len-1, older ones with lower slots
    always_comb begin
        eq = 1'b1;
        for (int a = 0; a < MAX_LEN; a++)
            if (len_ok && a < int'(len_q) && win[a] != pat_q[int'(len_q) - 1 - a]) eq = 1'b0;
    end

    assign hit    = accept && len_ok && (int'(fill_q) + 1 >= int'(len_q)) && eq;
    assign danger = (int'(cnt_q) == THRESH) || ((int'(cnt_q) == THRESH - 1) && hit);
    assign cnt    = cnt_q;
    assign match  = match_q;

    always_comb begin
        hist_d  = hist_q;
        pat_d   = pat_q;
        fill_d  = fill_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        match_d = 1'b0;
        if (clr) begin
            cnt_d  = '0;
            fill_d = '0;
        end else if (cfg_we || cfg_len_we) begin
            if (cfg_we && int'(cfg_idx) < MAX_LEN) pat_d[cfg_idx] = cfg_char;
            if (cfg_len_we) len_d = cfg_len;
            fill_d = '0;
        end else if (accept) begin
            hist_d[0] = in;
            for (int i = 1; i < MAX_LEN - 1; i++) hist_d[i] = hist_q[i-1];
            fill_d  = (int'(fill_q) == MAX_LEN) ? fill_q : fill_q + 1'b1;
            cnt_d   = cnt_q + 5'(hit);
            match_d = hit;
`ifndef DNA_MATCH_OVERLAP_EN
            if (hit) fill_d = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j < MAX_LEN - 1; j++) hist_q[j] <= '0;
            for (int j = 0; j < MAX_LEN; j++) pat_q[j] <= DEF_PAT[(MAX_LEN-1-j)*CHAR_W +: CHAR_W];
            fill_q  <= '0;
            len_q   <= LW'(DEF_LEN);
            cnt_q   <= '0;
            match_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            pat_q   <= pat_d;
            fill_q  <= fill_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
        end
    end
endmodule

// File: tb/tb_dna_seq_matcher.sv
// tb_dna_seq_matcher: directed scenarios plus random traffic against a queue-based model.
module tb_dna_seq_matcher;
    localparam int MAX_LEN = 8;
    localparam int THRESH  = 3;
    localparam int DEF_LEN = 8;

    logic       clk = 1'b0;
    logic       reset, in_valid, cfg_we, cfg_len_we, clr;
    logic [7:0] in_sym, cfg_char;
    logic [2:0] cfg_idx;
    logic [3:0] cfg_len;
    logic [4:0] cnt;
    logic       match, danger;

    int errors = 0;
    int checks = 0;

    string      def_s = "ATATGCGA";
    logic [7:0] mq [$];
    logic [7:0] mpat [MAX_LEN];
    int         mlen, mcnt;
    bit         mmatch;
    logic [7:0] acgt [4] = '{8'h41, 8'h43, 8'h47, 8'h54};

    always #5 clk = ~clk;

    dna_seq_matcher dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_sym),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_char(cfg_char),
        .cfg_len_we(cfg_len_we), .cfg_len(cfg_len), .clr(clr),
        .cnt(cnt), .match(match), .danger(danger)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    function automatic bit model_hit();
        logic [7:0] w [$];
        if (!(in_valid && !clr && !cfg_we && !cfg_len_we && mcnt < THRESH)) return 1'b0;
        if (mlen < 1 || mlen > MAX_LEN) return 1'b0;
        w = mq;
        w.push_back(in_sym);
        if (w.size() < mlen) return 1'b0;
        for (int k = 0; k < mlen; k++)
            if (w[w.size() - mlen + k] != mpat[k]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit model_danger();
        return (mcnt == THRESH) || (mcnt == THRESH - 1 && model_hit());
    endfunction

    task automatic model_reset();
        mq.delete();
        mcnt   = 0;
        mmatch = 1'b0;
        mlen   = DEF_LEN;
        for (int j = 0; j < MAX_LEN; j++) mpat[j] = def_s[j];
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) model_reset();
        else if (clr) begin
            mcnt = 0;
            mq.delete();
            mmatch = 1'b0;
        end else if (cfg_we || cfg_len_we) begin
            if (cfg_we && int'(cfg_idx) < MAX_LEN) mpat[cfg_idx] = cfg_char;
            if (cfg_len_we) mlen = int'(cfg_len);
            mq.delete();
            mmatch = 1'b0;
        end else if (in_valid && mcnt < THRESH) begin
            bit h;
            h = model_hit();
            mq.push_back(in_sym);
            if (mq.size() > MAX_LEN) void'(mq.pop_front());
            if (h) begin
                mcnt++;
`ifndef DNA_MATCH_OVERLAP_EN
                mq.delete();
`endif
            end
            mmatch = h;
        end else mmatch = 1'b0;
    end

    always @(negedge clk) begin
        chk("cnt", 32'(cnt), mcnt);
        chk("match", 32'(match), 32'(mmatch));
        chk("danger", 32'(danger), 32'(model_danger()));
    end

    task automatic idle();
        in_valid = 1'b0; cfg_we = 1'b0; cfg_len_we = 1'b0; clr = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) begin
            idle();
            in_valid = 1'b1;
            in_sym   = s[i];
            tick();
        end
        idle();
    endtask

    task automatic do_clr();
        idle(); clr = 1'b1; tick(); idle();
    endtask

    task automatic cfg(input logic [2:0] idx, input logic [7:0] ch, input bit lwe, input logic [3:0] l);
        idle();
        cfg_we = 1'b1; cfg_idx = idx; cfg_char = ch;
        cfg_len_we = lwe; cfg_len = l;
        tick();
        idle();
    endtask

    initial begin
        int exp036;
        idle();
        in_sym = 8'h00; cfg_idx = '0; cfg_char = '0; cfg_len = '0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("rst_cnt", 32'(cnt), 0);
        chk("rst_match", 32'(match), 0);
        chk("rst_danger", 32'(danger), 0);
        tick(); tick();
        reset = 1'b1;

        // default pattern, single full match
        send("ATATGCG");
        chk("d035_pre_match", 32'(match), 0);
        send("A");
        chk("d035_match", 32'(match), 1);
        chk("d035_cnt", 32'(cnt), 1);
        chk("d035_model_cnt", mcnt, 1);
        tick();
        chk("d035_match_end", 32'(match), 0);

        // short pattern ATA, overlap behaviour
        do_clr();
        cfg(3'd0, "A", 1'b1, 4'd3);
        cfg(3'd1, "T", 1'b0, 4'd0);
        cfg(3'd2, "A", 1'b0, 4'd0);
        send("ATATA");
`ifdef DNA_MATCH_OVERLAP_EN
        exp036 = 2;
`else
        exp036 = 1;
`endif
        chk("d036_cnt", 32'(cnt), exp036);
        chk("d036_model_cnt", mcnt, exp036);

        // lock at THRESH
        do_clr();
        send("ATAATA");
        chk("d037_cnt2", 32'(cnt), 2);
        send("AT");
        in_valid = 1'b1; in_sym = "A";
        #1 chk("d037_danger_pre", 32'(danger), 1);
        tick();
        idle();
        chk("d037_cnt3", 32'(cnt), 3);
        chk("d037_match", 32'(match), 1);
        send("ATA");
        chk("d037_cnt_held", 32'(cnt), 3);
        chk("d037_match_low", 32'(match), 0);
        chk("d037_danger_lock", 32'(danger), 1);

        // back to defaults; cfg write mid-stream restarts history
        reset = 1'b0; tick(); reset = 1'b1;
        send("ATAT");
        cfg(3'd7, "A", 1'b0, 4'd0);
        send("GCGA");
        chk("d038_cnt", 32'(cnt), 0);
        send("ATATGCGA");
        chk("d038_cnt_after", 32'(cnt), 1);

        // asynchronous reset mid-pattern
        send("ATATGC");
        #1 reset = 1'b0;
        #1;
        chk("d039_async_cnt", 32'(cnt), 0);
        chk("d039_async_match", 32'(match), 0);
        tick();
        reset = 1'b1;
        send("GA");
        chk("d039_cnt", 32'(cnt), 0);
        chk("d039_match", 32'(match), 0);

        // clr wins over a completing symbol
        send("ATATGCGA");
        chk("d040_pre_cnt", 32'(cnt), 1);
        send("ATATGCG");
        in_valid = 1'b1; in_sym = "A"; clr = 1'b1;
        tick();
        idle();
        chk("d040_cnt", 32'(cnt), 0);
        chk("d040_match", 32'(match), 0);

        // random traffic
        cfg(3'd0, "A", 1'b1, 4'd3);
        for (int n = 0; n < 3000; n++) begin
            idle();
            in_valid = ($urandom_range(0, 9) < 8);
            in_sym   = acgt[$urandom_range(0, 3)];
            clr      = ($urandom_range(0, 99) < 2);
            cfg_we   = ($urandom_range(0, 99) < 4);
            cfg_idx  = 3'($urandom_range(0, 7));
            cfg_char = acgt[$urandom_range(0, 3)];
            cfg_len_we = ($urandom_range(0, 99) < 3);
            cfg_len  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
            if ($urandom_range(0, 299) == 0) reset = 1'b0;
            tick();
            reset = 1'b1;
        end
        idle();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dna_seq_matcher.md
DNA_SEQ_MATCHER -- requirements
Module: dna_seq_matcher

Interface
REQ-001 SHALL have parameter CHAR_W, default 8, symbol width in bits.
REQ-002 SHALL have parameter MAX_LEN, default 8, maximum pattern length in symbols (2..16).
REQ-003 SHALL have parameter THRESH, default 3, match count at which the block locks (1..31).
REQ-004 SHALL have parameter DEF_PAT, default "ATATGCGA" (MAX_LEN*CHAR_W bits, first symbol in MSBs), pattern after reset.
REQ-005 SHALL have parameter DEF_LEN, default 8, pattern length after reset.
REQ-006 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-008 SHALL have port in_valid, input, 1, qualifies in.
REQ-009 SHALL have port in, input, CHAR_W, incoming symbol.
REQ-010 SHALL have port cfg_we, input, 1, pattern write strobe.
REQ-011 SHALL have port cfg_idx, input, clog2(MAX_LEN), pattern slot written (0 = first symbol).
REQ-012 SHALL have port cfg_char, input, CHAR_W, symbol written to slot cfg_idx.
REQ-013 SHALL have port cfg_len_we, input, 1, length write strobe.
REQ-014 SHALL have port cfg_len, input, clog2(MAX_LEN+1), new pattern length.
REQ-015 SHALL have port clr, input, 1, synchronous clear of count and history.
REQ-016 SHALL have port cnt, output, 5, registered match count.
REQ-017 SHALL have port match, output, 1, registered one-cycle pulse per counted match.
REQ-018 SHALL have port danger, output, 1, combinational lock/imminent-lock flag.

Function
REQ-019 SHALL keep a history of the last MAX_LEN accepted symbols plus a fill counter saturating at MAX_LEN.
REQ-020 SHALL accept a symbol only when in_valid=1, cnt<THRESH, cfg_we=0, cfg_len_we=0 and clr=0.
REQ-021 SHALL declare a hit on an accepted symbol when fill+1 >= len and the newest len symbols (including in) equal pattern slots 0..len-1, oldest first.
REQ-022 SHALL never hit when len=0 or len>MAX_LEN.
REQ-023 SHALL, on a hit, increment cnt by 1 and assert match for exactly the following cycle.
REQ-024 SHALL lock when cnt=THRESH: input ignored, history frozen, cnt held, match low.
REQ-025 SHALL drive danger = (cnt==THRESH) or (cnt==THRESH-1 and current cycle hits), with zero latency.
REQ-026 SHALL, on cfg_we or cfg_len_we, update the pattern/length at the edge and reset fill to 0; cnt retained.
REQ-027 SHALL, on clr, set cnt=0, fill=0, match=0; clr has priority over cfg writes and input.
REQ-028 SHALL give cfg_we and cfg_len_we equal priority; both in one cycle both take effect.
REQ-029 SHALL ignore cfg_idx values >= MAX_LEN.

Reset
REQ-030 SHALL, while reset=0, force cnt=0, match=0, fill=0, pattern=DEF_PAT, len=DEF_LEN, immediately and independent of clk.
REQ-031 SHALL, for reset asserted mid-match, discard partial history; first edge after release behaves as from power-up.
REQ-032 SHALL output danger=0 during reset when THRESH>1.

Configuration
REQ-033 SHALL, with macro DNA_MATCH_OVERLAP_EN defined, count overlapping matches (history kept after a hit).
REQ-034 SHALL, without DNA_MATCH_OVERLAP_EN, reset fill to 0 after every hit so matches never share symbols.

Verification
REQ-035 SHALL cover: default pattern, stream ATATGCGA -> match pulse after last A, cnt=1.
REQ-036 SHALL cover: len=3, pattern "ATA", stream ATATA -> cnt=2 with DNA_MATCH_OVERLAP_EN, cnt=1 without.
REQ-037 SHALL cover: THRESH=3, cnt=2, stream completes third match -> danger=1 in the completing cycle, cnt=3, then further matches leave cnt=3.
REQ-038 SHALL cover: stream ATAT, then cfg_we writes slot 7 mid-stream -> fill=0, GCGA alone gives no hit.
REQ-039 SHALL cover: reset low mid-pattern (after ATATGC) -> cnt=0, match=0 asynchronously; subsequent GA gives no hit.
REQ-040 SHALL cover: clr with in_valid completing a match in the same cycle -> cnt=0, match=0.
